// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit -- iterative RISC-V M-extension multiply/divide unit.
//
// Multiplies with a shift-add datapath and divides with a restoring datapath,
// both working on operand magnitudes, UNROLL radix-2 steps per clock. A final
// FIX cycle applies the sign. Divide-by-zero and signed overflow skip the
// datapath and finish one cycle after accept.
//
// Ports
//   clk_i     : clock, all state updates on the rising edge
//   rst_i     : asynchronous active-low reset
//   start_i   : request valid from EX stage
//   op_i      : funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU)
//   rs1_i     : dividend / multiplicand
//   rs2_i     : divisor / multiplier
//   flush_i   : abort any in-flight operation (wins over start_i)
//   busy_o    : stall request to the hazard unit
//   done_o    : one-cycle result-valid pulse
//   result_o  : result, held until the next accepted start completes
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // State and datapath registers. For multiply, opnd_q holds |multiplicand|
    // and {hi_q, lo_q} is the running product with the multiplier shifting
    // out of lo_q. For divide, opnd_q holds |divisor|, hi_q the partial
    // remainder and lo_q the dividend shifting out / quotient shifting in.
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       op_q,     op_d;
    logic             neg_q,    neg_d;
    logic [XLEN-1:0]  opnd_q,   opnd_d;
    logic [XLEN-1:0]  hi_q,     hi_d;
    logic [XLEN-1:0]  lo_q,     lo_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             accept;
    logic             rs1_signed, rs2_signed;
    logic             s1, s2;
    logic [XLEN-1:0]  mag1, mag2;
    logic             div_by_zero, sgn_overflow;
    logic [XLEN-1:0]  hi_n, lo_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix, rem_fix;
    logic [XLEN-1:0]  fix_result;

    assign accept = ((state_q == IDLE) || (state_q == DONE)) && start_i && !flush_i;

    // Operand decode at accept time.
    always_comb begin
        rs1_signed   = (op_i != OP_MULHU) && (op_i != OP_DIVU) && (op_i != OP_REMU);
        rs2_signed   = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                       (op_i == OP_DIV) || (op_i == OP_REM);
        s1           = rs1_signed && rs1_i[XLEN-1];
        s2           = rs2_signed && rs2_i[XLEN-1];
        mag1         = s1 ? -rs1_i : rs1_i;
        mag2         = s2 ? -rs2_i : rs2_i;
        div_by_zero  = op_i[2] && (rs2_i == '0);
        sgn_overflow = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (rs1_i == MOST_NEG) && (rs2_i == '1);
    end

    // UNROLL radix-2 steps of the iterative datapath.
    always_comb begin : calc_step
        logic [XLEN:0] sum;
        logic [XLEN:0] shifted;
        sum     = '0;
        shifted = '0;
        hi_n    = hi_q;
        lo_n    = lo_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                // Restoring divide: subtract only when it does not go negative.
                shifted = {hi_n, lo_n[XLEN-1]};
                if (shifted >= {1'b0, opnd_q}) begin
                    shifted = shifted - {1'b0, opnd_q};
                    lo_n    = {lo_n[XLEN-2:0], 1'b1};
                end else begin
                    lo_n    = {lo_n[XLEN-2:0], 1'b0};
                end
                hi_n = shifted[XLEN-1:0];
            end else begin
                // Shift-add: the carry out of the add becomes the new MSB.
                sum  = {1'b0, hi_n} + {1'b0, opnd_q & {XLEN{lo_n[0]}}};
                lo_n = {sum[0], lo_n[XLEN-1:1]};
                hi_n = sum[XLEN:1];
            end
        end
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets a hold default up front, so no path can leave a
        // variable unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = IDLE;
        end else if (accept) begin
            op_d  = op_i;
            neg_d = (op_i == OP_REM) ? s1 : (s1 ^ s2);
            cnt_d = '0;
            hi_d  = '0;
            if (op_i[2]) begin
                opnd_d = mag2;
                lo_d   = mag1;
            end else begin
                opnd_d = mag1;
                lo_d   = mag2;
            end
            if (div_by_zero) begin
                state_d  = DONE;
                result_d = op_i[1] ? rs1_i : '1;
            end else if (sgn_overflow) begin
                state_d  = DONE;
                result_d = op_i[1] ? '0 : rs1_i;
            end else begin
                state_d  = CALC;
            end
        end else begin
            case (state_q)
                CALC: begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) state_d = FIX;
                end
                FIX: begin
                    result_d = fix_result;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: every register, datapath included, is cleared by reset so no
    // stale operand can leak into a result after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    // busy_o is gated by rst_i so it drops immediately with reset even if
    // start_i is still high.
    assign busy_o   = rst_i && ((state_q == CALC) || (state_q == FIX) || accept);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit at default parameters.
//
// A transaction-level model (plain 64-bit arithmetic plus a predicted
// completion cycle) is compared against busy_o/done_o/result_o on every
// falling edge. Directed vectors additionally pin results and latencies to
// hand-computed literals.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int LAT_CALC = 34;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    muldiv_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the RISC-V M definitions.
    function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ub_s;
        logic [63:0] p;
        logic [63:0] ua, ub;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub_s = longint'({32'd0, b});
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub_s); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT_CALC;
    endfunction

    // Model state: at most one operation in flight.
    bit          m_pending = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_pend_res = '0;
    logic [31:0] m_result = '0;

    always @(negedge clk_i) begin : model_compare
        bit exp_done;
        bit exp_busy;
        if (rst_i !== 1'b1) begin
            m_pending = 1'b0;
            m_result  = '0;
            check("rst_busy", busy_o, 0);
            check("rst_done", done_o, 0);
            check("rst_result", result_o, 0);
        end else begin
            exp_done = m_pending && (cyc == m_done_at);
            if (exp_done) begin
                m_result  = m_pend_res;
                m_pending = 1'b0;
            end
            exp_busy = m_pending || (start_i && !flush_i);
            check("model_busy", busy_o, exp_busy);
            check("model_done", done_o, exp_done);
            check("model_result", result_o, m_result);
            if (m_pending && flush_i) begin
                m_pending = 1'b0;
            end else if (!m_pending && start_i && !flush_i) begin
                m_pending  = 1'b1;
                m_done_at  = cyc + ref_lat(op_i, rs1_i, rs2_i);
                m_pend_res = ref_fn(op_i, rs1_i, rs2_i);
            end
        end
    end

    // Drive one start cycle, then scramble the operands so late input changes
    // are exercised. Returns the cycle number in which start_i was high.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int sc);
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        sc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        op_i    = 3'($urandom);
        rs1_i   = $urandom;
        rs2_i   = $urandom;
    endtask

    task automatic wait_done(input int sc, input int exp_lat, input logic [31:0] exp_res,
                             input string name);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk_i);
            n++;
            if (done_o === 1'b1) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        if (seen) begin
            check({name, "_latency"}, cyc - sc, exp_lat);
            check({name, "_result"}, result_o, exp_res);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int sc;
        int sc2;
        int pulses;

        vecs = '{
            '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
            '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34},
            '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
            '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
            '{3'd5, 32'd100,       32'd7,         32'd14,        34},
            '{3'd7, 32'd100,       32'd7,         32'd2,         34},
            '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{3'd4, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, 1},
            '{3'd6, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFF6, 1},
            '{3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34},
            '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34},
            '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
            '{3'd4, 32'h8000_0000, 32'd2,         32'hC000_0000, 34}
        };

        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        op_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_result", result_o, 0);
        rst_i = 1'b1;

        // MUL with a start attempt mid-CALC that must be ignored.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, sc);
        repeat (4) @(posedge clk_i);
        #1;
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd9; rs2_i = 32'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("mul_busy_mid", busy_o, 1);
        wait_done(sc, 34, 32'hFFFF_FFEB, "mul_7x-3");

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, sc);
            wait_done(sc, vecs[i].lat, vecs[i].res, $sformatf("vec%0d", i));
        end

        // Flush ten cycles into a DIV: no done, busy drops, result kept.
        issue(3'd4, 32'd1000, 32'd3, sc);
        repeat (9) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy_low", busy_o, 0);
        check("flush_cycle", cyc - sc, 11);
        pulses = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o === 1'b1) pulses++;
        end
        check("flush_no_done", pulses, 0);
        check("flush_result_kept", result_o, 32'hC000_0000);

        // Back-to-back: new start in the DONE cycle of the previous op.
        issue(3'd0, 32'd3, 32'd5, sc);
        repeat (32) @(posedge clk_i);
        @(posedge clk_i); #1;
        check("b2b_done_cycle", cyc - sc, 34);
        check("b2b_done_high", done_o, 1);
        check("b2b_first_result", result_o, 32'd15);
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
        sc2 = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
        wait_done(sc2, 34, 32'd14, "b2b_divu");

        // Asynchronous reset in the middle of CALC.
        issue(3'd0, 32'h0000_1234, 32'h0000_0010, sc);
        repeat (5) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        check("async_rst_result", result_o, 0);
        check("async_rst_done", done_o, 0);
        check("async_rst_busy", busy_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4;
        sc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom;
        wait_done(sc, 34, 32'd12, "post_rst_mul");

        repeat (3) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
